// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and
// the requester index type.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // One bit selects core 0 or core 1.
    typedef logic req_idx_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single memory master port. One
// transaction outstanding at a time; contention is resolved by a priority
// bit that flips to the other core after each completed or timed-out
// transaction. A response that never arrives is reported as an error pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    addr_i,
    input  logic [NUM_REQ-1:0]                we_i,
    input  logic [NUM_REQ-1:0][DATA_W/8-1:0]  be_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]                gnt_o,
    output logic [NUM_REQ-1:0]                rvalid_o,
    output logic [NUM_REQ-1:0]                err_o,
    output logic [DATA_W-1:0]                 rdata_o,
    output logic                              mem_req_o,
    output logic [ADDR_W-1:0]                 mem_addr_o,
    output logic                              mem_we_o,
    output logic [DATA_W/8-1:0]               mem_be_o,
    output logic [DATA_W-1:0]                 mem_wdata_o,
    input  logic                              mem_gnt_i,
    input  logic                              mem_rvalid_i,
    input  logic [DATA_W-1:0]                 mem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    req_idx_t         owner_q, owner_d;
    req_idx_t         rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             timed_out;
    assign timed_out = (cnt_q == TO_LAST);

    // State, owner, priority bit and response-wait counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: arbitration in IDLE, grant/withdraw in REQ, response or timeout in RESP.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    // Both asking: priority bit decides; else the lone requester.
                    owner_d = (&req_i) ? rr_q : req_idx_t'(req_i[1]);
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else if (!req_i[owner_q]) begin
                    // Withdrawn before memory accepted it: no fairness update.
                    state_d = IDLE;
                end
            end
            RESP: begin
                // A response on the last wait cycle still counts as a response.
                if (mem_rvalid_i || timed_out) begin
                    rr_d    = ~owner_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: memory port muxed from owner in REQ, responses routed in RESP; all quiet in reset.
    always_comb begin
        gnt_o       = '0;
        rvalid_o    = '0;
        err_o       = '0;
        rdata_o     = '0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (!rst_i) begin
            unique case (state_q)
                REQ: begin
                    mem_req_o      = 1'b1;
                    mem_addr_o     = addr_i[owner_q];
                    mem_we_o       = we_i[owner_q];
                    mem_be_o       = be_i[owner_q];
                    mem_wdata_o    = wdata_i[owner_q];
                    gnt_o[owner_q] = mem_gnt_i;
                end
                RESP: begin
                    if (mem_rvalid_i) begin
                        rvalid_o[owner_q] = 1'b1;
                        rdata_o           = mem_rdata_i;
                    end else if (timed_out) begin
                        err_o[owner_q] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter. The bench plays both
// cores and the memory; a transaction-level model predicts the owner of each
// transaction and its outcome, and a separate monitor checks every response.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int T  = 16;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic [1:0]            req_i;
    logic [1:0][AW-1:0]    addr_i;
    logic [1:0]            we_i;
    logic [1:0][BW-1:0]    be_i;
    logic [1:0][DW-1:0]    wdata_i;
    logic [1:0]            gnt_o, rvalid_o, err_o;
    logic [DW-1:0]         rdata_o;
    logic                  mem_req_o, mem_we_o;
    logic [AW-1:0]         mem_addr_o;
    logic [BW-1:0]         mem_be_o;
    logic [DW-1:0]         mem_wdata_o;
    logic                  mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0]         mem_rdata_i;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .err_o(err_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic rr_m  = 1'b0;   // model of the fairness bit

    function automatic logic [1:0] onehot(input logic o);
        return o ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response the DUT presents must match the oldest prediction.
    always @(negedge clk) begin
        if (rvalid_o != 2'b00 || err_o != 2'b00) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: rvalid=%b err=%b, required no response", rvalid_o, err_o);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_rvalid", rvalid_o, mon_e.is_err ? 2'b00 : onehot(mon_e.owner));
                chk("sb_err", err_o, mon_e.is_err ? onehot(mon_e.owner) : 2'b00);
                chk("sb_rdata", rdata_o, mon_e.is_err ? 32'h0 : mon_e.data);
            end
        end else begin
            chk("rdata_idle", rdata_o, 0);
        end
    end

    // One full transaction: r = request pattern, stall = cycles without grant,
    // lat = RESP cycles before rvalid (lat >= T means no response -> timeout).
    task automatic txn(input logic [1:0] r, input int stall, input int lat,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d, input bit keep);
        logic w;
        w          = (r == 2'b11) ? rr_m : r[1];
        req_i      = r;
        addr_i[0]  = a0;
        addr_i[1]  = a1;
        we_i       = 2'($urandom);
        be_i[0]    = BW'($urandom);
        be_i[1]    = BW'($urandom);
        wdata_i[0] = $urandom;
        wdata_i[1] = $urandom;
        sb.push_back('{w, (lat >= T), d});
        @(negedge clk);
        chk("idle_mem_req", mem_req_o, 0);
        chk("idle_gnt", gnt_o, 0);
        step();
        for (int i = 0; i <= stall; i++) begin
            mem_gnt_i = (i == stall);
            @(negedge clk);
            chk("req_mem_req", mem_req_o, 1);
            chk("req_addr", mem_addr_o, (w ? a1 : a0));
            chk("req_we", mem_we_o, we_i[w]);
            chk("req_be", mem_be_o, be_i[w]);
            chk("req_wdata", mem_wdata_o, wdata_i[w]);
            chk("req_gnt", gnt_o, (i == stall) ? onehot(w) : 2'b00);
            step();
        end
        mem_gnt_i = 1'b0;
        if (!keep) req_i = 2'b00;
        for (int i = 0; i < T; i++) begin
            if (i == lat) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = d;
            end
            @(negedge clk);
            chk("resp_mem_req", mem_req_o, 0);
            chk("resp_rvalid", rvalid_o, (i == lat) ? onehot(w) : 2'b00);
            chk("resp_err", err_o, (lat >= T && i == T - 1) ? onehot(w) : 2'b00);
            step();
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;   // garbage while not valid
            if (i == lat) break;
        end
        rr_m = ~w;
    endtask

    // Idle cycle, then a stray memory response that must be ignored.
    task automatic spurious();
        req_i = 2'b00;
        @(negedge clk);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = $urandom;
        @(negedge clk);
        chk("spur_rvalid", rvalid_o, 0);
        chk("spur_mem_req", mem_req_o, 0);
        step();
        mem_rvalid_i = 1'b0;
    endtask

    // Requester p raises req, then drops it before the memory grants.
    task automatic withdraw(input logic p);
        req_i     = onehot(p);
        addr_i[p] = $urandom;
        @(negedge clk);
        step();
        req_i     = 2'b00;
        mem_gnt_i = 1'b0;
        @(negedge clk);
        chk("wd_mem_req_req", mem_req_o, 1);
        chk("wd_gnt", gnt_o, 0);
        step();
        @(negedge clk);
        chk("wd_back_idle", mem_req_o, 0);
        step();
    endtask

    // Get into RESP, pulse reset, then deliver a late response.
    task automatic reset_in_resp();
        req_i     = 2'b01;
        addr_i[0] = $urandom;
        @(negedge clk);
        step();
        mem_gnt_i = 1'b1;
        @(negedge clk);
        step();
        mem_gnt_i = 1'b0;
        req_i     = 2'b00;
        rst_i     = 1'b1;
        mem_rvalid_i = 1'b1;   // also arriving during reset
        @(negedge clk);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_err", err_o, 0);
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk("late_rvalid", rvalid_o, 0);
        chk("late_mem_req", mem_req_o, 0);
        step();
        mem_rvalid_i = 1'b0;
        rr_m = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; req_i = '0; addr_i = '0; we_i = '0; be_i = '0; wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_gnt", gnt_o, 0);
        chk("reset_mem_req", mem_req_o, 0);
        chk("reset_rvalid_err", {rvalid_o, err_o}, 0);
        step();
        rst_i = 1'b0;

        // Single request, immediate grant, response next cycle.
        txn(2'b01, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);

        // Contention after reset: owners must alternate 0,1,0,1.
        rst_i = 1'b1; step(); rst_i = 1'b0; rr_m = 1'b0;
        for (int k = 0; k < 4; k++)
            txn(2'b11, $urandom_range(0, 2), $urandom_range(0, 3), $urandom, $urandom, $urandom, 1'b1);

        // Stalled grant on core 1.
        txn(2'b10, 5, 2, $urandom, 32'hA5A5_0010, $urandom, 1'b0);

        // Timeout, then a stray response two cycles later.
        txn(2'b11, 0, T, $urandom, $urandom, $urandom, 1'b0);
        spurious();

        // Withdrawal leaves fairness alone; contention afterwards shows it.
        withdraw(~rr_m);
        txn(2'b11, 0, 1, $urandom, $urandom, $urandom, 1'b0);

        // Reset mid-response; priority back to core 0.
        reset_in_resp();
        txn(2'b11, 1, 0, $urandom, $urandom, $urandom, 1'b0);

        for (int k = 0; k < 60; k++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) withdraw(1'($urandom));
            else if (kind == 1) reset_in_resp();
            else if (kind == 2) spurious();
            else txn(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, T + 1),
                     $urandom, $urandom, $urandom, 1'($urandom));
        end

        req_i = 2'b00;
        repeat (3) step();
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
